// File: rtl/dcache_pkg.sv
// Shared types, field widths and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } cache_state_t;

   localparam int ADDR_BITS   = 16;
   localparam int WORD_BITS   = 16;
   localparam int LINE_BITS   = 64;
   localparam int OFFSET_BITS = 2;
   localparam int DEFAULT_IDX_BITS = 2;
   localparam int DEFAULT_TAG_BITS = ADDR_BITS - OFFSET_BITS - DEFAULT_IDX_BITS;

   function automatic int tag_width(input int idx_bits);
      return ADDR_BITS - OFFSET_BITS - idx_bits;
   endfunction

   // Word k of a line lives in bits [16k+15:16k].
   function automatic logic [WORD_BITS-1:0] select_word(input logic [LINE_BITS-1:0] line,
                                                        input logic [OFFSET_BITS-1:0] offset);
      return line[offset*WORD_BITS +: WORD_BITS];
   endfunction

endpackage

// File: rtl/dcache_direct_if.sv
// CPU request/response and memory control signals of the data cache.
interface dcache_direct_if;

   logic        cpu_readM;
   logic        cpu_writeM;
   logic [15:0] cpu_address;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;

   logic        mem_readM;
   logic        mem_writeM;
   logic [15:0] mem_address;
   logic        mem_ready;

   // master is the surrounding system (CPU + memory); slave is the cache itself
   modport master (
      output cpu_readM, cpu_writeM, cpu_address, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      input  mem_readM, mem_writeM, mem_address,
      output mem_ready
   );

   modport slave (
      input  cpu_readM, cpu_writeM, cpu_address, cpu_wdata,
      output cpu_rdata, cpu_ready,
      output mem_readM, mem_writeM, mem_address,
      input  mem_ready
   );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one combinational read port, a line-write and a word-write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int IDX_BITS  = 2,
   parameter int TAG_BITS  = 12,
   parameter int WORD_SIZE = 16,
   parameter int LINE_SIZE = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IDX_BITS-1:0]  rd_index,
   output logic                 rd_valid,
   output logic [TAG_BITS-1:0]  rd_tag,
   output logic [LINE_SIZE-1:0] rd_line,
   input  logic                 line_we,
   input  logic [IDX_BITS-1:0]  line_index,
   input  logic [TAG_BITS-1:0]  line_tag,
   input  logic [LINE_SIZE-1:0] line_data,
   input  logic                 word_we,
   input  logic [IDX_BITS-1:0]  word_index,
   input  logic [OFFSET_BITS-1:0] word_offset,
   input  logic [WORD_SIZE-1:0] word_data
);

   localparam int NUM_LINES = 1 << IDX_BITS;

   logic [NUM_LINES-1:0] valid;
   logic [TAG_BITS-1:0]  tags  [NUM_LINES];
   logic [LINE_SIZE-1:0] lines [NUM_LINES];

   // Only the valid bits are reset; tag and data are meaningless until a fill.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid <= '0;
      end else if (line_we) begin
         valid[line_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tags[line_index]  <= line_tag;
         lines[line_index] <= line_data;
      end else if (word_we) begin
         lines[word_index][word_offset*WORD_SIZE +: WORD_SIZE] <= word_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_line  = lines[rd_index];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_direct
   import dcache_pkg::*;
#(
   parameter int IDX_BITS  = 2,
   parameter int WORD_SIZE = 16,
   parameter int LINE_SIZE = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   dcache_direct_if.slave       bus,
   inout  wire  [LINE_SIZE-1:0] mem_data
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]          hit_count,
   output logic [15:0]          miss_count
`endif
);

   localparam int TAG_BITS = tag_width(IDX_BITS);

   cache_state_t state, state_next;

   logic [TAG_BITS-1:0]    addr_tag;
   logic [IDX_BITS-1:0]    addr_index;
   logic [OFFSET_BITS-1:0] addr_offset;
   logic                   rd_valid;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [LINE_SIZE-1:0]   rd_line;
   logic                   hit;
   logic                   write_drive;
   logic [WORD_SIZE-1:0]   fill_word;
   logic                   line_we;
   logic                   word_we;
   logic                   read_hit_evt;
   logic                   read_miss_evt;

   assign addr_tag    = bus.cpu_address[ADDR_BITS-1 -: TAG_BITS];
   assign addr_index  = bus.cpu_address[OFFSET_BITS +: IDX_BITS];
   assign addr_offset = bus.cpu_address[OFFSET_BITS-1:0];
   assign hit         = rd_valid && (rd_tag == addr_tag);

   // The write enable is kept apart from the FSM block so the bus drive never loops back through it.
   assign write_drive = reset_n && (state == IDLE) && bus.cpu_writeM && !bus.cpu_readM && bus.mem_ready;
   assign mem_data    = write_drive ? {{(LINE_SIZE-WORD_SIZE){1'b0}}, bus.cpu_wdata} : {LINE_SIZE{1'bz}};
   assign fill_word   = select_word(mem_data, addr_offset);

   dcache_array #(
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS),
      .WORD_SIZE(WORD_SIZE),
      .LINE_SIZE(LINE_SIZE)
   ) u_array (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_index   (addr_index),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .rd_line    (rd_line),
      .line_we    (line_we),
      .line_index (addr_index),
      .line_tag   (addr_tag),
      .line_data  (mem_data),
      .word_we    (word_we),
      .word_index (addr_index),
      .word_offset(addr_offset),
      .word_data  (bus.cpu_wdata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // All outputs stay low while reset is asserted, even mid-fill.
   always_comb begin
      state_next      = state;
      bus.cpu_ready   = 1'b0;
      bus.cpu_rdata   = '0;
      bus.mem_readM   = 1'b0;
      bus.mem_writeM  = 1'b0;
      bus.mem_address = '0;
      line_we         = 1'b0;
      word_we         = 1'b0;
      read_hit_evt    = 1'b0;
      read_miss_evt   = 1'b0;
      if (reset_n) begin
         case (state)
            IDLE: begin
               if (bus.cpu_readM) begin
                  if (hit) begin
                     bus.cpu_ready = 1'b1;
                     bus.cpu_rdata = select_word(rd_line, addr_offset);
                     read_hit_evt  = 1'b1;
                  end else if (bus.mem_ready) begin
                     bus.mem_readM   = 1'b1;
                     bus.mem_address = bus.cpu_address;
                     read_miss_evt   = 1'b1;
                     state_next      = FILL;
                  end
               end else if (write_drive) begin
                  bus.mem_writeM  = 1'b1;
                  bus.mem_address = bus.cpu_address;
                  bus.cpu_ready   = 1'b1;
                  word_we         = hit;
               end
            end
            FILL: begin
               bus.mem_address = bus.cpu_address;
               if (bus.mem_ready) begin
                  bus.mem_readM = 1'b1;
                  line_we       = 1'b1;
                  bus.cpu_ready = 1'b1;
                  bus.cpu_rdata = fill_word;
                  state_next    = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (read_hit_evt && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
         end
         if (read_miss_evt && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = read_hit_evt | read_miss_evt;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Randomized bench for dcache_direct with a blocking-handshake memory and a line-level reference model.
`timescale 1ns/1ps
module tb_dcache_direct;

   localparam int MAX_WAIT = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   wire  [63:0] mem_data;
   dcache_direct_if bus();
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Memory device: accepts on strobe && ready, then stays busy for five cycles.
   logic [15:0] memArray [65536];
   logic [15:0] refMem   [65536];
   logic        memReadyInt = 1'b1;
   logic        forceBusy = 1'b0;
   int          busyLeft = 0;
   logic [13:0] pendingLine = '0;
   logic [63:0] memLine;

   // Reference cache: which line address each index holds.
   bit          refValid [4];
   logic [13:0] refLine  [4];
   int          expHits = 0;
   int          expMisses = 0;
   int          lastIssueCycle;

   always #5 clk = ~clk;

   dcache_direct dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .mem_data  (mem_data)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   assign bus.mem_ready = memReadyInt & ~forceBusy;
   assign memLine = {memArray[{pendingLine, 2'd3}], memArray[{pendingLine, 2'd2}],
                     memArray[{pendingLine, 2'd1}], memArray[{pendingLine, 2'd0}]};
   assign mem_data = (bus.mem_readM && bus.mem_ready) ? memLine : 64'bz;

   always @(posedge clk) begin
      if (busyLeft > 0) begin
         busyLeft <= busyLeft - 1;
         if (busyLeft == 1) memReadyInt <= 1'b1;
      end else if (bus.mem_ready && (bus.mem_readM || bus.mem_writeM)) begin
         memReadyInt <= 1'b0;
         busyLeft    <= 5;
         if (bus.mem_writeM) memArray[bus.mem_address] <= mem_data[15:0];
         else                pendingLine <= bus.mem_address[15:2];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // A strobe must never be raised while the memory is busy.
   always begin
      @(negedge clk);
      #2;
      if (reset_n && (bus.mem_readM || bus.mem_writeM))
         checkOutput("strobeWhileBusy", 64'(bus.mem_ready), 64'd1);
   end

   task automatic applyStimulus(input bit isWrite, input logic [15:0] addr, input logic [15:0] wdata,
                                output logic [15:0] rdata, output int readyCycle,
                                output int firstReadyCycle, output int issueCycle, output int strobeCount,
                                output logic [15:0] issueAddr, output logic [63:0] issueData);
      @(negedge clk);
      bus.cpu_readM   = !isWrite;
      bus.cpu_writeM  = isWrite;
      bus.cpu_address = addr;
      bus.cpu_wdata   = wdata;
      rdata = '0; readyCycle = -1; firstReadyCycle = -1; issueCycle = -1;
      strobeCount = 0; issueAddr = '0; issueData = '0;
      for (int c = 0; c < MAX_WAIT; c++) begin
         #1;
         if (firstReadyCycle < 0 && bus.mem_ready) firstReadyCycle = c;
         if (bus.mem_readM || bus.mem_writeM) begin
            strobeCount++;
            if (issueCycle < 0) begin
               issueCycle = c;
               issueAddr  = bus.mem_address;
               issueData  = mem_data;
            end
         end
         if (bus.cpu_ready) begin
            readyCycle = c;
            rdata      = bus.cpu_rdata;
            break;
         end
         @(negedge clk);
      end
      if (readyCycle < 0) checkOutput("readyTimeout", 64'(bus.cpu_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.cpu_readM  = 1'b0;
      bus.cpu_writeM = 1'b0;
   endtask

   task automatic runAccess(input bit isWrite, input logic [15:0] addr, input logic [15:0] wdata);
      int idx;
      bit expHit;
      logic [15:0] rdata;
      logic [15:0] issueAddr;
      logic [63:0] issueData;
      int readyCycle, firstReady, issueCycle, strobes;
      idx    = int'(addr[3:2]);
      expHit = refValid[idx] && (refLine[idx] == addr[15:2]);
      applyStimulus(isWrite, addr, wdata, rdata, readyCycle, firstReady, issueCycle, strobes, issueAddr, issueData);
      lastIssueCycle = issueCycle;
      if (isWrite) begin
         checkOutput("wrStrobes", 64'(strobes), 64'd1);
         checkOutput("wrIssueCycle", 64'(issueCycle), 64'(firstReady));
         checkOutput("wrReadyCycle", 64'(readyCycle), 64'(issueCycle));
         checkOutput("wrAddr", 64'(issueAddr), 64'(addr));
         checkOutput("wrData", issueData, {48'b0, wdata});
         refMem[addr] = wdata;
      end else begin
         checkOutput("rdData", 64'(rdata), 64'(refMem[addr]));
         if (expHit) begin
            checkOutput("hitCycle", 64'(readyCycle), 64'd0);
            checkOutput("hitStrobes", 64'(strobes), 64'd0);
            expHits++;
         end else begin
            checkOutput("missStrobes", 64'(strobes), 64'd2);
            checkOutput("missIssueCycle", 64'(issueCycle), 64'(firstReady));
            checkOutput("missLatency", 64'(readyCycle), 64'(issueCycle + 6));
            checkOutput("missAddr", 64'(issueAddr), 64'(addr));
            refValid[idx] = 1'b1;
            refLine[idx]  = addr[15:2];
            expMisses++;
         end
      end
   endtask

   task automatic waitMemReady();
      for (int c = 0; c < MAX_WAIT; c++) begin
         @(negedge clk);
         #1;
         if (bus.mem_ready) return;
      end
      checkOutput("memReadyTimeout", 64'(bus.mem_ready), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit isWrite;
      logic [15:0] addr;
      for (int i = 0; i < 65536; i++) begin
         memArray[i] = 16'($urandom);
         refMem[i]   = memArray[i];
      end
      memArray[16'h0021] = 16'h0000; refMem[16'h0021] = 16'h0000;
      memArray[16'h0023] = 16'h6000; refMem[16'h0023] = 16'h6000;
      memArray[16'h0024] = 16'hF01C; refMem[16'h0024] = 16'hF01C;
      memArray[16'h0034] = 16'hF41C; refMem[16'h0034] = 16'hF41C;
      for (int i = 0; i < 4; i++) refValid[i] = 1'b0;

      // Requests held during reset must produce no response or strobe.
      bus.cpu_readM = 1'b1; bus.cpu_writeM = 1'b0; bus.cpu_address = 16'h0023; bus.cpu_wdata = 16'h1234;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rstReady", 64'(bus.cpu_ready), 64'd0);
      checkOutput("rstMemRead", 64'(bus.mem_readM), 64'd0);
      checkOutput("rstMemAddr", 64'(bus.mem_address), 64'd0);
      checkOutput("rstRdata", 64'(bus.cpu_rdata), 64'd0);
      @(negedge clk);
      bus.cpu_readM = 1'b0; bus.cpu_writeM = 1'b1;
      #1;
      checkOutput("rstMemWrite", 64'(bus.mem_writeM), 64'd0);
      checkOutput("rstWrReady", 64'(bus.cpu_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.cpu_writeM = 1'b0;

      runAccess(1'b0, 16'h0023, 16'h0);
      runAccess(1'b0, 16'h0021, 16'h0);
      waitMemReady();
      runAccess(1'b1, 16'h0022, 16'hBEEF);
      runAccess(1'b0, 16'h0022, 16'h0);
      runAccess(1'b0, 16'h0024, 16'h0);
      runAccess(1'b0, 16'h0034, 16'h0);
      runAccess(1'b0, 16'h0024, 16'h0);
`ifdef DCACHE_STATS_EN
      #1;
      checkOutput("hitCountDirected", 64'(hit_count), 64'd2);
      checkOutput("missCountDirected", 64'(miss_count), 64'd4);
`endif

      // Write miss while the memory is held busy for three cycles.
      waitMemReady();
      forceBusy = 1'b1;
      fork
         runAccess(1'b1, 16'h0050, 16'hA5A5);
         begin
            repeat (3) @(negedge clk);
            forceBusy = 1'b0;
         end
      join
      checkOutput("stallIssueCycle", 64'(lastIssueCycle), 64'd2);
      runAccess(1'b0, 16'h0050, 16'h0);

      // Reset asserted in the fourth cycle of a fill.
      waitMemReady();
      @(negedge clk);
      bus.cpu_readM = 1'b1; bus.cpu_address = 16'h0014;
      #1;
      checkOutput("fillIssue", 64'(bus.mem_readM), 64'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) refValid[i] = 1'b0;
      #1;
      checkOutput("midFillRstReady", 64'(bus.cpu_ready), 64'd0);
      checkOutput("midFillRstRead", 64'(bus.mem_readM), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.cpu_readM = 1'b0;
      expHits = 0;
      expMisses = 0;
      runAccess(1'b0, 16'h0023, 16'h0);

      for (int n = 0; n < 150; n++) begin
         isWrite = ($urandom_range(0, 2) == 0);
         addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
         runAccess(isWrite, addr, 16'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
`ifdef DCACHE_STATS_EN
      #1;
      checkOutput("hitCount", 64'(hit_count), 64'(expHits));
      checkOutput("missCount", 64'(miss_count), 64'(expMisses));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
